// File: rtl/uart_imem_loader_pkg.sv
// rtl/uart_imem_loader_pkg.sv - shared state encodings and baud-divider constants for the UART image loader
package uart_imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Integer division truncates, so the bit period is rounded down.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                     input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_imem_loader_uart_rx.sv
// rtl/uart_imem_loader_uart_rx.sv - 8N1 UART receiver with input synchronizer
module uart_rx
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 23000000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CPB  = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF = CPB / 2;
  localparam int          CW   = $clog2(CPB);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic            rx_meta, rx_sync, rx_prev;
  logic            fall;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            valid_n, ferr_n;

  assign fall      = rx_prev & ~rx_sync;
  assign byte_data = shreg;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // Start-bit qualification at half a bit, then sample every full bit from the start midpoint.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (fall) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_sync) begin
            state_n = RX_IDLE;
          end else begin
            state_n   = RX_DATA;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CPB_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CPB_M1) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_sync) begin
            valid_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - loads a length-prefixed instruction image from UART into IMEM
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 23000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned IMEM_AW     = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  input  logic               load_start,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [32:0] DEPTH = 33'd1 << IMEM_AW;

  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               frame_err;

  load_state_t        state, state_n;
  logic [1:0]         byte_cnt;
  logic [31:0]        word_sr;
  logic [IMEM_AW-1:0] index;
  logic [IMEM_AW-1:0] n_last;

  logic [31:0]        assembled;
  logic               word_done;
  logic               len_bad;
  logic               in_load;
  logic               restart;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Little-endian: each new byte enters at the top, so after four bytes the first is at [7:0].
  assign assembled = {byte_data, word_sr[31:8]};
  assign word_done = byte_valid && (byte_cnt == 2'd3);
  assign len_bad   = (assembled == 32'd0) || ({1'b0, assembled} > DEPTH);
  assign in_load   = (state == ST_LEN) || (state == ST_DATA);
  assign restart   = load_start && ((state == ST_DONE) || (state == ST_ERR));

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LEN;
    end else begin
      state <= state_n;
    end
  end

  // Next state and status outputs; DONE is entered on the cycle of the last write so
  // load_done rises the cycle after that imem_we.
  always_comb begin
    state_n   = state;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    unique case (state)
      ST_LEN: begin
        if (frame_err) begin
          state_n = ST_ERR;
        end else if (word_done) begin
          state_n = len_bad ? ST_ERR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (frame_err) begin
          state_n = ST_ERR;
        end else if (imem_we && (index == n_last)) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (load_start) state_n = ST_LEN;
      end
      ST_ERR: begin
        load_err = 1'b1;
        if (load_start) state_n = ST_LEN;
      end
      default: state_n = ST_LEN;
    endcase
  end

  // Byte assembly, word index and the registered IMEM write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt   <= '0;
      word_sr    <= '0;
      index      <= '0;
      n_last     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;

      if (restart) begin
        byte_cnt <= '0;
        word_sr  <= '0;
        index    <= '0;
      end else if (byte_valid && in_load) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_sr  <= assembled;
      end

      if ((state == ST_LEN) && word_done && !len_bad) begin
        n_last <= IMEM_AW'(assembled - 32'd1);
        index  <= '0;
      end

      if ((state == ST_DATA) && word_done) begin
        imem_we    <= 1'b1;
        imem_addr  <= index;
        imem_wdata <= assembled;
      end

      // The index parks on the last word so it never runs past N-1.
      if ((state == ST_DATA) && imem_we && (index != n_last)) begin
        index <= index + IMEM_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 62_500;
  localparam int unsigned AW     = 3;
  localparam int          CPB    = 16;
  localparam int          DEPTH  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          load_start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, load_done, load_err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  logic        done_prev = 1'b0;

  logic [7:0]  tx_bytes[$];
  logic [31:0] exp_words[$];
  bit          exp_done, exp_err;

  uart_imem_loader #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .IMEM_AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .load_start(load_start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every IMEM write and the cycle load_done first rises.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (load_done && !done_prev) done_cyc = cyc;
    done_prev = load_done;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    last_we_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(tx_bytes[i], 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic start_load();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic make_image(input int n);
    logic [31:0] w;
    tx_bytes.delete();
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'((n >> (8 * i)) & 255));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int i = 0; i < 4; i++) tx_bytes.push_back(w[8*i +: 8]);
    end
  endtask

  // Reference: whole byte stream in, expected writes and final status out.
  task automatic model_load();
    longint n;
    exp_words.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (tx_bytes.size() < 4) return;
    n = longint'({tx_bytes[3], tx_bytes[2], tx_bytes[1], tx_bytes[0]});
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (tx_bytes.size() >= 4 * w + 8)
        exp_words.push_back({tx_bytes[4*w+7], tx_bytes[4*w+6], tx_bytes[4*w+5], tx_bytes[4*w+4]});
    end
    exp_done = (exp_words.size() == n);
  endtask

  task automatic compare_result(input string tag);
    check({tag, " nwr"}, longint'(wr_addr.size()), longint'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), longint'(wr_addr[i]), longint'(i));
      check($sformatf("%s data%0d", tag, i), longint'(wr_data[i]), longint'(exp_words[i]));
    end
    check({tag, " done"}, longint'(load_done), longint'(exp_done));
    check({tag, " err"},  longint'(load_err),  longint'(exp_err));
    check({tag, " hold"}, longint'(cpu_hold),  longint'(!exp_done));
    if (exp_done) check({tag, " done lag"}, longint'(done_cyc - last_we_cyc), 64'sd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hold"},  longint'(cpu_hold),   64'sd1);
    check({tag, " done"},  longint'(load_done),  64'sd0);
    check({tag, " err"},   longint'(load_err),   64'sd0);
    check({tag, " we"},    longint'(imem_we),    64'sd0);
    check({tag, " addr"},  longint'(imem_addr),  64'sd0);
    check({tag, " wdata"}, longint'(imem_wdata), 64'sd0);
  endtask

  task automatic run_image(input string tag);
    model_load();
    send_range(0, tx_bytes.size());
    compare_result(tag);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst in");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst out");

    // Two-word image with fixed contents.
    clear_mon();
    tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                 8'h93, 8'h05, 8'h10, 8'h00};
    run_image("n2");
    check("n2 w0 fixed", longint'(wr_data.size() > 0 ? wr_data[0] : 32'hdead_beef), 64'h0000_0513);
    check("n2 w1 fixed", longint'(wr_data.size() > 1 ? wr_data[1] : 32'hdead_beef), 64'h0010_0593);

    // Zero length.
    start_load();
    clear_mon();
    tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_image("n0");

    // Bad stop bit on the third data byte, then recovery with a one-word image.
    start_load();
    clear_mon();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h37, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr err",  longint'(load_err),       64'sd1);
    check("ferr hold", longint'(cpu_hold),       64'sd1);
    check("ferr nwr",  longint'(wr_addr.size()), 64'sd0);
    start_load();
    check("restart err clr", longint'(load_err), 64'sd0);
    clear_mon();
    make_image(1);
    run_image("recover");

    // Short low glitch while waiting for the length must not produce a byte.
    start_load();
    clear_mon();
    uart_rx = 1'b0;
    repeat (CPB / 2 - 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch hold", longint'(cpu_hold), 64'sd1);
    check("glitch err",  longint'(load_err), 64'sd0);
    make_image(2);
    run_image("glitch");

    // Reset partway through word 1 of a three-word load.
    start_load();
    clear_mon();
    make_image(3);
    send_range(0, 10);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst nwr", longint'(wr_addr.size()), 64'sd1);
    check_reset_outputs("midrst");
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    clear_mon();
    make_image(3);
    run_image("postrst");

    // One past the memory depth.
    start_load();
    clear_mon();
    make_image(0);
    tx_bytes[0] = 8'(DEPTH + 1);
    run_image("over");

    // Full depth, with a load_start pulse mid-image that must be ignored.
    start_load();
    clear_mon();
    make_image(DEPTH);
    model_load();
    send_range(0, 12);
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    send_range(12, tx_bytes.size());
    compare_result("full");
    check("full last addr", longint'(wr_addr.size() > 0 ? wr_addr[$] : -1), longint'(DEPTH - 1));

    // Randomly sized images.
    for (int r = 0; r < 3; r++) begin
      start_load();
      clear_mon();
      make_image(int'($urandom_range(1, DEPTH)));
      run_image($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
